// File: rtl/trap_pkg.sv
// Shared types and constants for the trap unit: FSM states, interrupt codes,
// WARL write masks, plus the RISC-V CSR address macros used by the CSR decode.
`ifndef RISCV_CSR_DEFINES
`define RISCV_CSR_DEFINES
`define CSR_SIE      12'h104
`define CSR_SSCRATCH 12'h140
`define CSR_SEPC     12'h141
`define CSR_SCAUSE   12'h142
`define CSR_STVAL    12'h143
`define CSR_SIP      12'h144
`define CSR_MEDELEG  12'h302
`define CSR_MIDELEG  12'h303
`define CSR_MIE      12'h304
`define CSR_MSCRATCH 12'h340
`define CSR_MEPC     12'h341
`define CSR_MCAUSE   12'h342
`define CSR_MTVAL    12'h343
`define CSR_MIP      12'h344
`endif

package trap_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_e;

    localparam logic [5:0] IRQ_SSI = 6'd1;
    localparam logic [5:0] IRQ_MSI = 6'd3;
    localparam logic [5:0] IRQ_STI = 6'd5;
    localparam logic [5:0] IRQ_MTI = 6'd7;
    localparam logic [5:0] IRQ_SEI = 6'd9;
    localparam logic [5:0] IRQ_MEI = 6'd11;

    localparam logic [15:0] MIP_WMASK     = 16'h0222;
    localparam logic [15:0] MIE_WMASK     = 16'h0AAA;
    localparam logic [15:0] MIDELEG_WMASK = 16'h0222;
    localparam logic [15:0] MEDELEG_WMASK = 16'hF7FF;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser bringing asynchronous interrupt lines into clk_i.
module irq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= d_i;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// Trap/interrupt CSR block: holds M/S trap CSRs, takes traps from commit,
// presents a redirect to fetch, and selects the highest-priority interrupt.
module trap_unit
    import trap_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int SYNC_STAGES = 2,
    parameter bit HAS_SMODE   = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      irq_i,
    input  logic [1:0]      priv_i,
    input  logic            mstatus_mie_i,
    input  logic            mstatus_sie_i,
    input  logic            csr_wr_valid_i,
    input  logic [11:0]     csr_wr_idx_i,
    input  logic [XLEN-1:0] csr_wr_data_i,
    input  logic [11:0]     csr_rd_idx_i,
    output logic [XLEN-1:0] csr_rd_data_o,
    output logic            csr_rd_hit_o,
    input  logic            trap_valid_i,
    output logic            trap_ready_o,
    input  logic            trap_async_i,
    input  logic [5:0]      trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    output logic            redir_valid_o,
    input  logic            redir_ready_i,
    output logic            redir_to_s_o,
    output logic [XLEN-1:0] redir_cause_o,
    output logic            irq_valid_o,
    output logic [5:0]      irq_cause_o
);

    localparam logic [XLEN-1:0] MIP_M     = XLEN'(MIP_WMASK);
    localparam logic [XLEN-1:0] MIE_M     = XLEN'(MIE_WMASK);
    localparam logic [XLEN-1:0] MIDELEG_M = XLEN'(MIDELEG_WMASK);
    localparam logic [XLEN-1:0] MEDELEG_M = XLEN'(MEDELEG_WMASK);

    trap_state_e     r_state, w_state_nxt;
    logic [XLEN-1:0] r_mip_sw, r_mie, r_mideleg, r_medeleg;
    logic [XLEN-1:0] r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [XLEN-1:0] r_sscratch, r_sepc, r_scause, r_stval;
    logic            r_redir_to_s;
    logic [XLEN-1:0] r_redir_cause;
    logic            r_irq_valid;
    logic [5:0]      r_irq_cause;

    logic [3:0]      w_irq_s;
    logic [XLEN-1:0] w_mip, w_sip_wm, w_sie_wm, w_xcause, w_epc;
    logic            w_hs, w_deleg, w_to_s;
    logic [11:0]     w_pend, w_cand;
    logic            w_m_en, w_s_en, w_irq_any;
    logic [5:0]      w_irq_code;

    irq_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_irq_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (irq_i),
        .q_o   (w_irq_s)
    );

    // irq_i = {sei,mti,msi,mei} lands on mip bits 9,7,3,11
    assign w_mip = r_mip_sw | XLEN'({w_irq_s[0], 1'b0, w_irq_s[3], 1'b0,
                                     w_irq_s[2], 3'b000, w_irq_s[1], 3'b000});
    assign w_sip_wm = MIP_M & r_mideleg;
    assign w_sie_wm = MIE_M & r_mideleg;

    assign w_hs     = trap_valid_i & (r_state == ST_IDLE);
    assign w_deleg  = trap_async_i ? r_mideleg[trap_cause_i] : r_medeleg[trap_cause_i];
    assign w_to_s   = HAS_SMODE & (priv_i != 2'd3) & w_deleg;
    assign w_xcause = {trap_async_i, {(XLEN-7){1'b0}}, trap_cause_i};
    assign w_epc    = {trap_pc_i[XLEN-1:1], 1'b0};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (trap_valid_i)  w_state_nxt = ST_REDIR;
            ST_REDIR: if (redir_ready_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mip_sw      <= '0;
            r_mie         <= '0;
            r_mideleg     <= '0;
            r_medeleg     <= '0;
            r_mscratch    <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_sscratch    <= '0;
            r_sepc        <= '0;
            r_scause      <= '0;
            r_stval       <= '0;
            r_redir_to_s  <= 1'b0;
            r_redir_cause <= '0;
        end else begin
            if (csr_wr_valid_i) begin
                case (csr_wr_idx_i)
                    `CSR_MIP:      r_mip_sw   <= csr_wr_data_i & MIP_M;
                    `CSR_MIE:      r_mie      <= csr_wr_data_i & MIE_M;
                    `CSR_MIDELEG:  if (HAS_SMODE) r_mideleg <= csr_wr_data_i & MIDELEG_M;
                    `CSR_MEDELEG:  if (HAS_SMODE) r_medeleg <= csr_wr_data_i & MEDELEG_M;
                    `CSR_MSCRATCH: r_mscratch <= csr_wr_data_i;
                    `CSR_MEPC:     r_mepc     <= {csr_wr_data_i[XLEN-1:1], 1'b0};
                    `CSR_MCAUSE:   r_mcause   <= csr_wr_data_i;
                    `CSR_MTVAL:    r_mtval    <= csr_wr_data_i;
                    `CSR_SIP: if (HAS_SMODE)
                        r_mip_sw <= (r_mip_sw & ~w_sip_wm) | (csr_wr_data_i & w_sip_wm);
                    `CSR_SIE: if (HAS_SMODE)
                        r_mie <= (r_mie & ~w_sie_wm) | (csr_wr_data_i & w_sie_wm);
                    `CSR_SSCRATCH: if (HAS_SMODE) r_sscratch <= csr_wr_data_i;
                    `CSR_SEPC:     if (HAS_SMODE) r_sepc <= {csr_wr_data_i[XLEN-1:1], 1'b0};
                    `CSR_SCAUSE:   if (HAS_SMODE) r_scause <= csr_wr_data_i;
                    `CSR_STVAL:    if (HAS_SMODE) r_stval  <= csr_wr_data_i;
                    default: ;
                endcase
            end
            // Placed after the CSR write so the trap wins on the target's epc/cause/tval
            if (w_hs) begin
                r_redir_to_s  <= w_to_s;
                r_redir_cause <= w_xcause;
                if (w_to_s) begin
                    r_sepc   <= w_epc;
                    r_scause <= w_xcause;
                    r_stval  <= trap_tval_i;
                end else begin
                    r_mepc   <= w_epc;
                    r_mcause <= w_xcause;
                    r_mtval  <= trap_tval_i;
                end
            end
        end
    end

    always_comb begin
        csr_rd_data_o = '0;
        csr_rd_hit_o  = 1'b0;
        case (csr_rd_idx_i)
            `CSR_MIP:      begin csr_rd_hit_o = 1'b1; csr_rd_data_o = w_mip;      end
            `CSR_MIE:      begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mie;      end
            `CSR_MIDELEG:  begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mideleg;  end
            `CSR_MEDELEG:  begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_medeleg;  end
            `CSR_MSCRATCH: begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mscratch; end
            `CSR_MEPC:     begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mepc;     end
            `CSR_MCAUSE:   begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mcause;   end
            `CSR_MTVAL:    begin csr_rd_hit_o = 1'b1; csr_rd_data_o = r_mtval;    end
            `CSR_SIP:      begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = w_mip & r_mideleg; end
            `CSR_SIE:      begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = r_mie & r_mideleg; end
            `CSR_SSCRATCH: begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = r_sscratch; end
            `CSR_SEPC:     begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = r_sepc;     end
            `CSR_SCAUSE:   begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = r_scause;   end
            `CSR_STVAL:    begin csr_rd_hit_o = HAS_SMODE; csr_rd_data_o = r_stval;    end
            default: ;
        endcase
    end

    assign w_pend = w_mip[11:0] & r_mie[11:0];
    assign w_m_en = (priv_i != 2'd3) | mstatus_mie_i;
    assign w_s_en = (priv_i == 2'd0) | ((priv_i == 2'd1) & mstatus_sie_i);
    assign w_cand = w_pend & ((~r_mideleg[11:0] & {12{w_m_en}}) |
                              ( r_mideleg[11:0] & {12{w_s_en}}));

    always_comb begin
        w_irq_any  = 1'b1;
        w_irq_code = '0;
        if      (w_cand[IRQ_MEI]) w_irq_code = IRQ_MEI;
        else if (w_cand[IRQ_MSI]) w_irq_code = IRQ_MSI;
        else if (w_cand[IRQ_MTI]) w_irq_code = IRQ_MTI;
        else if (w_cand[IRQ_SEI]) w_irq_code = IRQ_SEI;
        else if (w_cand[IRQ_SSI]) w_irq_code = IRQ_SSI;
        else if (w_cand[IRQ_STI]) w_irq_code = IRQ_STI;
        else                      w_irq_any  = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_valid <= 1'b0;
            r_irq_cause <= '0;
        end else begin
            r_irq_valid <= w_irq_any;
            r_irq_cause <= w_irq_code;
        end
    end

    assign trap_ready_o  = (r_state == ST_IDLE);
    assign redir_valid_o = (r_state == ST_REDIR);
    assign redir_to_s_o  = r_redir_to_s;
    assign redir_cause_o = r_redir_cause;
    // Interrupts are masked for the whole redirect so commit cannot start a second trap
    assign irq_valid_o   = r_irq_valid & (r_state == ST_IDLE);
    assign irq_cause_o   = (r_state == ST_IDLE) ? r_irq_cause : 6'd0;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: CSR WARL table, trap/redirect sequences,
// interrupt latency and priority, backpressure and reset in REDIR.
module tb_trap_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  irq_i;
    logic [1:0]  priv_i;
    logic        mstatus_mie_i, mstatus_sie_i;
    logic        csr_wr_valid_i;
    logic [11:0] csr_wr_idx_i, csr_rd_idx_i;
    logic [63:0] csr_wr_data_i, csr_rd_data_o;
    logic        csr_rd_hit_o;
    logic        trap_valid_i, trap_ready_o, trap_async_i;
    logic [5:0]  trap_cause_i;
    logic [63:0] trap_pc_i, trap_tval_i;
    logic        redir_valid_o, redir_ready_i, redir_to_s_o;
    logic [63:0] redir_cause_o;
    logic        irq_valid_o;
    logic [5:0]  irq_cause_o;

    int total = 0;
    int bad   = 0;

    trap_unit #(.XLEN(64), .SYNC_STAGES(2), .HAS_SMODE(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .priv_i(priv_i),
        .mstatus_mie_i(mstatus_mie_i), .mstatus_sie_i(mstatus_sie_i),
        .csr_wr_valid_i(csr_wr_valid_i), .csr_wr_idx_i(csr_wr_idx_i),
        .csr_wr_data_i(csr_wr_data_i), .csr_rd_idx_i(csr_rd_idx_i),
        .csr_rd_data_o(csr_rd_data_o), .csr_rd_hit_o(csr_rd_hit_o),
        .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o),
        .trap_async_i(trap_async_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
        .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
        .redir_to_s_o(redir_to_s_o), .redir_cause_o(redir_cause_o),
        .irq_valid_o(irq_valid_o), .irq_cause_o(irq_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wen;
        logic [11:0] widx;
        logic [63:0] wdata;
        logic [11:0] ridx;
        logic [63:0] exp;
        logic        exp_hit;
    } vec_t;

    localparam logic [11:0] A_SIE = 12'h104, A_SSCR = 12'h140, A_SEPC = 12'h141;
    localparam logic [11:0] A_SCAU = 12'h142, A_STVAL = 12'h143, A_SIP = 12'h144;
    localparam logic [11:0] A_MEDG = 12'h302, A_MIDG = 12'h303, A_MIE = 12'h304;
    localparam logic [11:0] A_MSCR = 12'h340, A_MEPC = 12'h341, A_MCAU = 12'h342;
    localparam logic [11:0] A_MTVAL = 12'h343, A_MIP = 12'h344;
    localparam logic [63:0] ONES = '1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [11:0] idx, input logic [63:0] exp);
        csr_rd_idx_i = idx;
        #1;
        chk(name, csr_rd_data_o, exp);
    endtask

    task automatic csr_wr(input logic [11:0] idx, input logic [63:0] data);
        csr_wr_valid_i = 1'b1;
        csr_wr_idx_i   = idx;
        csr_wr_data_i  = data;
        tick();
        csr_wr_valid_i = 1'b0;
    endtask

    // Drives one trap into the handshake edge; caller may also hold a CSR write
    task automatic trap(input logic async, input logic [5:0] cause,
                        input logic [63:0] pc, input logic [63:0] tval);
        trap_valid_i = 1'b1;
        trap_async_i = async;
        trap_cause_i = cause;
        trap_pc_i    = pc;
        trap_tval_i  = tval;
        tick();
        trap_valid_i = 1'b0;
    endtask

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{1'b1, A_MIE,   ONES,                   A_MIE,   64'hAAA,                  1'b1};
        vecs[1]  = '{1'b1, A_MIDG,  ONES,                   A_MIDG,  64'h222,                  1'b1};
        vecs[2]  = '{1'b1, A_MEDG,  ONES,                   A_MEDG,  64'hF7FF,                 1'b1};
        vecs[3]  = '{1'b1, A_MIP,   ONES,                   A_MIP,   64'h222,                  1'b1};
        vecs[4]  = '{1'b0, 12'h0,   64'h0,                  A_SIP,   64'h222,                  1'b1};
        vecs[5]  = '{1'b0, 12'h0,   64'h0,                  A_SIE,   64'h222,                  1'b1};
        vecs[6]  = '{1'b1, A_SIE,   64'h0,                  A_MIE,   64'h888,                  1'b1};
        vecs[7]  = '{1'b1, A_SIP,   64'h0,                  A_MIP,   64'h0,                    1'b1};
        vecs[8]  = '{1'b1, A_MEPC,  64'h1235,               A_MEPC,  64'h1234,                 1'b1};
        vecs[9]  = '{1'b1, A_SEPC,  64'h8000_0003,          A_SEPC,  64'h8000_0002,            1'b1};
        vecs[10] = '{1'b1, A_MSCR,  64'hDEAD_BEEF_CAFE_F00D, A_MSCR, 64'hDEAD_BEEF_CAFE_F00D,  1'b1};
        vecs[11] = '{1'b1, A_SSCR,  64'h55,                 A_SSCR,  64'h55,                   1'b1};
        vecs[12] = '{1'b1, A_MTVAL, 64'h77,                 A_MTVAL, 64'h77,                   1'b1};
        vecs[13] = '{1'b1, A_STVAL, 64'h99,                 A_STVAL, 64'h99,                   1'b1};
        vecs[14] = '{1'b1, A_MCAU,  64'h8000_0000_0000_0005, A_MCAU, 64'h8000_0000_0000_0005,  1'b1};
        vecs[15] = '{1'b1, A_SCAU,  64'h3,                  A_SCAU,  64'h3,                    1'b1};
        vecs[16] = '{1'b0, 12'h0,   64'h0,                  12'h300, 64'h0,                    1'b0};
        vecs[17] = '{1'b1, A_MIDG,  64'h0,                  A_SIE,   64'h0,                    1'b1};
        vecs[18] = '{1'b1, A_MEDG,  64'h100,                A_MEDG,  64'h100,                  1'b1};
        vecs[19] = '{1'b1, A_MIE,   64'h0,                  A_MIE,   64'h0,                    1'b1};

        rst_i = 1'b1; irq_i = '0; priv_i = 2'd3;
        mstatus_mie_i = 1'b0; mstatus_sie_i = 1'b0;
        csr_wr_valid_i = 1'b0; csr_wr_idx_i = '0; csr_wr_data_i = '0; csr_rd_idx_i = '0;
        trap_valid_i = 1'b0; trap_async_i = 1'b0; trap_cause_i = '0;
        trap_pc_i = '0; trap_tval_i = '0; redir_ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;

        chk("rst redir_valid", 64'(redir_valid_o), 64'd0);
        chk("rst irq_valid", 64'(irq_valid_o), 64'd0);
        chk("rst trap_ready", 64'(trap_ready_o), 64'd1);
        rd_chk("rst mepc", A_MEPC, 64'h0);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wen) csr_wr(vecs[i].widx, vecs[i].wdata);
            rd_chk($sformatf("vec%0d data", i), vecs[i].ridx, vecs[i].exp);
            chk($sformatf("vec%0d hit", i), 64'(csr_rd_hit_o), 64'(vecs[i].exp_hit));
        end

        // Delegated ecall from U lands in S-mode
        priv_i = 2'd0;
        chk("s-trap ready", 64'(trap_ready_o), 64'd1);
        trap(1'b0, 6'd8, 64'h8000_0003, 64'h11);
        chk("s-trap redir_valid", 64'(redir_valid_o), 64'd1);
        chk("s-trap to_s", 64'(redir_to_s_o), 64'd1);
        chk("s-trap cause", redir_cause_o, 64'd8);
        rd_chk("s-trap sepc", A_SEPC, 64'h8000_0002);
        rd_chk("s-trap scause", A_SCAU, 64'd8);
        rd_chk("s-trap stval", A_STVAL, 64'h11);
        tick();
        chk("s-trap redir done", 64'(redir_valid_o), 64'd0);
        rd_chk("s-trap mepc kept", A_MEPC, 64'h1234);

        // Same ecall from M stays in M
        csr_wr(A_SEPC, 64'h500);
        priv_i = 2'd3;
        trap(1'b0, 6'd8, 64'h8000_0003, 64'h22);
        chk("m-trap to_s", 64'(redir_to_s_o), 64'd0);
        rd_chk("m-trap mepc", A_MEPC, 64'h8000_0002);
        rd_chk("m-trap mcause", A_MCAU, 64'd8);
        rd_chk("m-trap sepc kept", A_SEPC, 64'h500);
        tick();

        // CSR write colliding with the trap on the same edge
        csr_wr_valid_i = 1'b1; csr_wr_idx_i = A_MEPC; csr_wr_data_i = 64'h1234;
        trap(1'b0, 6'd2, 64'h40, 64'h0);
        csr_wr_valid_i = 1'b0;
        rd_chk("coll mepc", A_MEPC, 64'h40);
        rd_chk("coll mcause", A_MCAU, 64'd2);
        tick();
        csr_wr_valid_i = 1'b1; csr_wr_idx_i = A_MSCR; csr_wr_data_i = 64'hABC;
        trap(1'b0, 6'd2, 64'h80, 64'h0);
        csr_wr_valid_i = 1'b0;
        rd_chk("coll mscratch", A_MSCR, 64'hABC);
        rd_chk("coll mepc2", A_MEPC, 64'h80);
        tick();

        // MEI latency through the synchroniser
        mstatus_mie_i = 1'b1;
        csr_wr(A_MIE, 64'h800);
        irq_i = 4'b0001;
        tick();
        chk("irq lat c1", 64'(irq_valid_o), 64'd0);
        tick();
        chk("irq lat c2", 64'(irq_valid_o), 64'd0);
        tick();
        chk("irq lat c3 valid", 64'(irq_valid_o), 64'd1);
        chk("irq lat c3 cause", 64'(irq_cause_o), 64'd11);
        rd_chk("irq mip", A_MIP, 64'h800);
        irq_i = 4'b0000;
        tick(); tick(); tick();
        chk("irq cleared", 64'(irq_valid_o), 64'd0);

        // MTI beats SEI
        csr_wr(A_MIE, 64'h280);
        irq_i = 4'b1100;
        tick(); tick(); tick();
        chk("prio valid", 64'(irq_valid_o), 64'd1);
        chk("prio cause", 64'(irq_cause_o), 64'd7);
        rd_chk("prio mip", A_MIP, 64'h280);

        // Held redirect under backpressure, then reset mid-REDIR
        redir_ready_i = 1'b0;
        trap(1'b1, 6'd7, 64'h100, 64'h0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d redir_valid", c), 64'(redir_valid_o), 64'd1);
            chk($sformatf("bp%0d trap_ready", c), 64'(trap_ready_o), 64'd0);
            chk($sformatf("bp%0d cause", c), redir_cause_o, 64'h8000_0000_0000_0007);
            chk($sformatf("bp%0d irq masked", c), 64'(irq_valid_o), 64'd0);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rr redir_valid", 64'(redir_valid_o), 64'd0);
        chk("rr trap_ready", 64'(trap_ready_o), 64'd1);
        chk("rr to_s", 64'(redir_to_s_o), 64'd0);
        chk("rr cause", redir_cause_o, 64'd0);
        chk("rr irq_valid", 64'(irq_valid_o), 64'd0);
        chk("rr irq_cause", 64'(irq_cause_o), 64'd0);
        rd_chk("rr mepc", A_MEPC, 64'h0);
        rd_chk("rr mie", A_MIE, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
